// File: rtl/ikaz_zamanlayici.sv
// Cabin buzzer scheduler: turns seat-belt and door warning levels into timed beep/silence
// patterns, door first, with a beep budget for the seat belt. Optional mute input: IKAZ_SUSTURMA_EN.
module ikaz_zamanlayici #(
  parameter int BIP_SURESI    = 4,
  parameter int SESSIZ_SURESI = 4,
  parameter int TEKRAR_SAYISI = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       motor_durumu,
  input  logic       emniyet_kemeri_ikaz,
  input  logic       kapi_ikaz,
`ifdef IKAZ_SUSTURMA_EN
  input  logic       sustur,
`endif
  output logic       buzzer,
  output logic [1:0] aktif_kaynak,
  output logic       kemer_bitti,
  output logic [1:0] durum_dbg
);

  typedef enum logic [1:0] {
    BOSTA  = 2'd0,
    BIP    = 2'd1,
    SESSIZ = 2'd2
  } durum_t;

  localparam logic [1:0] KAYNAK_YOK   = 2'b00;
  localparam logic [1:0] KAYNAK_KEMER = 2'b01;
  localparam logic [1:0] KAYNAK_KAPI  = 2'b10;

  localparam int FAZ_MAX = (BIP_SURESI > SESSIZ_SURESI) ? BIP_SURESI : SESSIZ_SURESI;
  localparam int FAZ_W   = $clog2(FAZ_MAX + 1);
  localparam int SAY_W   = $clog2(TEKRAR_SAYISI + 2);

  localparam logic [FAZ_W-1:0] BIP_SON    = FAZ_W'(BIP_SURESI - 1);
  localparam logic [FAZ_W-1:0] SESSIZ_SON = FAZ_W'(SESSIZ_SURESI - 1);
  localparam logic [SAY_W-1:0] SAY_HEDEF  = SAY_W'(TEKRAR_SAYISI);

  durum_t             r_durum;
  logic [1:0]         r_kaynak;
  logic [FAZ_W-1:0]   r_faz;
  logic [SAY_W-1:0]   r_bip_say;
  logic               r_kemer_bitti;
  logic               r_kemer_sus;
  logic               r_kapi_sus;
  logic               r_buzzer;
  logic [1:0]         r_aktif;

  durum_t             w_durum_n;
  logic [1:0]         w_kaynak_n;
  logic [FAZ_W-1:0]   w_faz_n;
  logic [SAY_W-1:0]   w_say_n;
  logic [SAY_W-1:0]   w_say_art;
  logic               w_bitti_n;
  logic               w_kemer_sus_n;
  logic               w_kapi_sus_n;
  logic               w_hakem;
  logic               w_kaynak_istek;
  logic               w_kapi_uygun;
  logic               w_kemer_uygun;
  logic               w_sustur;

`ifdef IKAZ_SUSTURMA_EN
  assign w_sustur = sustur;
`else
  assign w_sustur = 1'b0;
`endif

  assign w_say_art = r_bip_say + SAY_W'(1);

  always_comb begin
    w_durum_n      = r_durum;
    w_kaynak_n     = r_kaynak;
    w_faz_n        = r_faz;
    w_say_n        = r_bip_say;
    w_bitti_n      = r_kemer_bitti;
    w_kemer_sus_n  = r_kemer_sus;
    w_kapi_sus_n   = r_kapi_sus;
    w_hakem        = 1'b0;
    w_kapi_uygun   = 1'b0;
    w_kemer_uygun  = 1'b0;
    w_kaynak_istek = (r_kaynak == KAYNAK_KAPI) ? kapi_ikaz : emniyet_kemeri_ikaz;

    if (!motor_durumu) begin
      w_durum_n     = BOSTA;
      w_kaynak_n    = KAYNAK_YOK;
      w_faz_n       = '0;
      w_say_n       = '0;
      w_bitti_n     = 1'b0;
      w_kemer_sus_n = 1'b0;
      w_kapi_sus_n  = 1'b0;
    end else begin
      if (r_durum != BOSTA && w_sustur) begin
        if (r_kaynak == KAYNAK_KAPI) w_kapi_sus_n = 1'b1;
        else                         w_kemer_sus_n = 1'b1;
        w_durum_n  = BOSTA;
        w_kaynak_n = KAYNAK_YOK;
        w_faz_n    = '0;
      end else if (r_durum != BOSTA && !w_kaynak_istek) begin
        w_durum_n  = BOSTA;
        w_kaynak_n = KAYNAK_YOK;
        w_faz_n    = '0;
      end else begin
        unique case (r_durum)
          BOSTA: w_hakem = 1'b1;
          BIP: begin
            if (r_faz == BIP_SON) begin
              w_durum_n = SESSIZ;
              w_faz_n   = '0;
            end else begin
              w_faz_n = r_faz + FAZ_W'(1);
            end
          end
          SESSIZ: begin
            if (r_faz == SESSIZ_SON) begin
              // Budget is charged when the silence ends, so the final beep is heard in full.
              if (r_kaynak == KAYNAK_KEMER && TEKRAR_SAYISI != 0) begin
                w_say_n = w_say_art;
                if (w_say_art == SAY_HEDEF) w_bitti_n = 1'b1;
              end
              w_hakem = 1'b1;
            end else begin
              w_faz_n = r_faz + FAZ_W'(1);
            end
          end
          default: begin
            w_durum_n  = BOSTA;
            w_kaynak_n = KAYNAK_YOK;
            w_faz_n    = '0;
          end
        endcase
      end

      // Uses the updated budget flag so an exhausted seat belt cannot start a fourth beep.
      w_kapi_uygun  = kapi_ikaz && !r_kapi_sus;
      w_kemer_uygun = emniyet_kemeri_ikaz && !r_kemer_sus && !w_bitti_n;

      if (w_hakem) begin
        w_faz_n = '0;
        if (w_kapi_uygun) begin
          w_durum_n  = BIP;
          w_kaynak_n = KAYNAK_KAPI;
        end else if (w_kemer_uygun) begin
          w_durum_n  = BIP;
          w_kaynak_n = KAYNAK_KEMER;
        end else begin
          w_durum_n  = BOSTA;
          w_kaynak_n = KAYNAK_YOK;
        end
      end

      if (!emniyet_kemeri_ikaz) begin
        w_say_n       = '0;
        w_bitti_n     = 1'b0;
        w_kemer_sus_n = 1'b0;
      end
      if (!kapi_ikaz) w_kapi_sus_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_durum       <= BOSTA;
      r_kaynak      <= KAYNAK_YOK;
      r_faz         <= '0;
      r_bip_say     <= '0;
      r_kemer_bitti <= 1'b0;
      r_kemer_sus   <= 1'b0;
      r_kapi_sus    <= 1'b0;
      r_buzzer      <= 1'b0;
      r_aktif       <= KAYNAK_YOK;
    end else begin
      r_durum       <= w_durum_n;
      r_kaynak      <= w_kaynak_n;
      r_faz         <= w_faz_n;
      r_bip_say     <= w_say_n;
      r_kemer_bitti <= w_bitti_n;
      r_kemer_sus   <= w_kemer_sus_n;
      r_kapi_sus    <= w_kapi_sus_n;
      r_buzzer      <= (w_durum_n == BIP);
      r_aktif       <= (w_durum_n == BOSTA) ? KAYNAK_YOK : w_kaynak_n;
    end
  end

  assign buzzer       = r_buzzer;
  assign aktif_kaynak = r_aktif;
  assign kemer_bitti  = r_kemer_bitti;
  assign durum_dbg    = r_durum;

endmodule

// File: tb/tb_ikaz_zamanlayici.sv
// Bench for ikaz_zamanlayici: pattern-position model checked every cycle, plus directed
// literal checks for reset, beep budget, drop, door priority, engine-off and (optional) mute.
module tb_ikaz_zamanlayici;

  localparam int BIP = 4;
  localparam int SES = 4;
  localparam int TEK = 3;
  localparam int PER = BIP + SES;

  logic       clk = 1'b0;
  logic       rst;
  logic       motor_durumu;
  logic       emniyet_kemeri_ikaz;
  logic       kapi_ikaz;
  logic       sustur;
  logic       buzzer;
  logic [1:0] aktif_kaynak;
  logic       kemer_bitti;
  logic [1:0] durum_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ikaz_zamanlayici #(
    .BIP_SURESI   (BIP),
    .SESSIZ_SURESI(SES),
    .TEKRAR_SAYISI(TEK)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .motor_durumu       (motor_durumu),
    .emniyet_kemeri_ikaz(emniyet_kemeri_ikaz),
    .kapi_ikaz          (kapi_ikaz),
`ifdef IKAZ_SUSTURMA_EN
    .sustur             (sustur),
`endif
    .buzzer             (buzzer),
    .aktif_kaynak       (aktif_kaynak),
    .kemer_bitti        (kemer_bitti),
    .durum_dbg          (durum_dbg)
  );

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bekle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: source owning the buzzer, position inside the beep period, seat-belt beeps done.
  int m_src, m_t, m_cnt;
  bit m_done, m_mute_k, m_mute_d, m_valid;

  initial begin
    bit arb, req, s_eff;
    m_valid = 0; m_src = 0; m_t = 0; m_cnt = 0;
    m_done = 0; m_mute_k = 0; m_mute_d = 0;
    forever begin
      @(posedge clk);
`ifdef IKAZ_SUSTURMA_EN
      s_eff = sustur;
`else
      s_eff = 1'b0;
`endif
      if (rst || !motor_durumu) begin
        m_src = 0; m_t = 0; m_cnt = 0;
        m_done = 0; m_mute_k = 0; m_mute_d = 0;
        if (rst) m_valid = 1;
      end else begin
        arb = 0;
        req = (m_src == 2) ? kapi_ikaz : emniyet_kemeri_ikaz;
        if (m_src == 0) arb = 1;
        else if (s_eff) begin
          if (m_src == 2) m_mute_d = 1; else m_mute_k = 1;
          m_src = 0;
        end else if (!req) m_src = 0;
        else if (m_t == PER - 1) begin
          if (m_src == 1) begin
            m_cnt++;
            if (TEK != 0 && m_cnt == TEK) m_done = 1;
          end
          arb = 1;
        end else m_t++;
        if (arb) begin
          m_t = 0;
          if (kapi_ikaz && !m_mute_d) m_src = 2;
          else if (emniyet_kemeri_ikaz && !m_mute_k && !m_done) m_src = 1;
          else m_src = 0;
        end
        if (!emniyet_kemeri_ikaz) begin m_cnt = 0; m_done = 0; m_mute_k = 0; end
        if (!kapi_ikaz) m_mute_d = 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("mdl_buzzer", {7'd0, buzzer}, {7'd0, (m_src != 0 && m_t < BIP)});
        chk("mdl_aktif", {6'd0, aktif_kaynak}, 8'(m_src));
        chk("mdl_bitti", {7'd0, kemer_bitti}, {7'd0, m_done});
      end
    end
  end

  initial begin
    int hi;
    int n2;
    rst = 1; motor_durumu = 1; emniyet_kemeri_ikaz = 1; kapi_ikaz = 1; sustur = 0;

    // Reset with both requests high
    bekle(3);
    chk("rst_buzzer", {7'd0, buzzer}, 8'd0);
    chk("rst_aktif", {6'd0, aktif_kaynak}, 8'd0);
    chk("rst_bitti", {7'd0, kemer_bitti}, 8'd0);
    chk("rst_durum", {6'd0, durum_dbg}, 8'd0);
    rst = 0;
    bekle(1);
    chk("t1_buzzer", {7'd0, buzzer}, 8'd1);
    chk("t1_aktif_kapi", {6'd0, aktif_kaynak}, 8'd2);
    chk("t1_durum_bip", {6'd0, durum_dbg}, 8'd1);

    // Seat belt alone: three beeps then muted by budget
    rst = 1; kapi_ikaz = 0;
    bekle(2);
    rst = 0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      bekle(1);
      hi += int'(buzzer);
      if (i == 0)  chk("t2_aktif0", {6'd0, aktif_kaynak}, 8'd1);
      if (i == 3)  chk("t2_bip_son", {7'd0, buzzer}, 8'd1);
      if (i == 4)  chk("t2_sessiz_ilk", {7'd0, buzzer}, 8'd0);
      if (i == 8)  chk("t2_bip2", {7'd0, buzzer}, 8'd1);
      if (i == 23) chk("t2_bitti_23", {7'd0, kemer_bitti}, 8'd0);
      if (i == 24) chk("t2_bitti_24", {7'd0, kemer_bitti}, 8'd1);
    end
    chk("t2_bip_sayisi", 8'(hi), 8'd12);

    // Seat belt drop mid-beep, then fresh budget
    emniyet_kemeri_ikaz = 0;
    bekle(2);
    chk("t3_bitti_temiz", {7'd0, kemer_bitti}, 8'd0);
    emniyet_kemeri_ikaz = 1;
    bekle(1);
    bekle(9);
    chk("t3_bip2_ici", {7'd0, buzzer}, 8'd1);
    emniyet_kemeri_ikaz = 0;
    bekle(1);
    chk("t3_drop_buzzer", {7'd0, buzzer}, 8'd0);
    chk("t3_drop_aktif", {6'd0, aktif_kaynak}, 8'd0);
    chk("t3_drop_bitti", {7'd0, kemer_bitti}, 8'd0);
    emniyet_kemeri_ikaz = 1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      bekle(1);
      hi += int'(buzzer);
    end
    chk("t3_yeni_bip_sayisi", 8'(hi), 8'd12);

    // Door arrives during seat-belt beep: waits, then owns; seat belt resumes with 2 left
    emniyet_kemeri_ikaz = 0;
    bekle(2);
    emniyet_kemeri_ikaz = 1;
    bekle(1);
    bekle(1);
    kapi_ikaz = 1;
    bekle(6);
    chk("t4_c7_aktif", {6'd0, aktif_kaynak}, 8'd1);
    chk("t4_c7_buzzer", {7'd0, buzzer}, 8'd0);
    bekle(1);
    chk("t4_c8_aktif", {6'd0, aktif_kaynak}, 8'd2);
    chk("t4_c8_buzzer", {7'd0, buzzer}, 8'd1);
    bekle(21);
    chk("t4_kapi_aktif", {6'd0, aktif_kaynak}, 8'd2);
    chk("t4_kapi_bitti", {7'd0, kemer_bitti}, 8'd0);
    kapi_ikaz = 0;
    bekle(1);
    chk("t4_kapi_dus", {6'd0, aktif_kaynak}, 8'd0);
    bekle(1);
    chk("t4_kemer_geri", {6'd0, aktif_kaynak}, 8'd1);
    hi = int'(buzzer);
    for (int i = 0; i < 30; i++) begin
      bekle(1);
      hi += int'(buzzer);
    end
    chk("t4_kalan_bip", 8'(hi), 8'd8);
    chk("t4_bitti", {7'd0, kemer_bitti}, 8'd1);

    // Engine off mid door beep
    kapi_ikaz = 1;
    bekle(1);
    chk("t5_kapi_bip", {6'd0, aktif_kaynak}, 8'd2);
    bekle(1);
    motor_durumu = 0;
    bekle(1);
    chk("t5_buzzer", {7'd0, buzzer}, 8'd0);
    chk("t5_aktif", {6'd0, aktif_kaynak}, 8'd0);
    chk("t5_bitti", {7'd0, kemer_bitti}, 8'd0);
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      bekle(1);
      hi += int'(buzzer);
    end
    chk("t5_sessizlik", 8'(hi), 8'd0);
    motor_durumu = 1;
    bekle(1);
    chk("t5_motor_geri", {6'd0, aktif_kaynak}, 8'd2);

`ifdef IKAZ_SUSTURMA_EN
    // Mute during door beep: seat belt takes over, door silent until re-asserted
    bekle(1);
    sustur = 1;
    bekle(1);
    sustur = 0;
    chk("t6_buzzer", {7'd0, buzzer}, 8'd0);
    chk("t6_aktif", {6'd0, aktif_kaynak}, 8'd0);
    bekle(1);
    chk("t6_kemer", {6'd0, aktif_kaynak}, 8'd1);
    n2 = 0;
    for (int i = 0; i < 40; i++) begin
      bekle(1);
      n2 += (aktif_kaynak == 2'd2) ? 1 : 0;
    end
    chk("t6_kapi_sessiz", 8'(n2), 8'd0);
    kapi_ikaz = 0;
    bekle(1);
    kapi_ikaz = 1;
    bekle(1);
    chk("t6_kapi_geri", {6'd0, aktif_kaynak}, 8'd2);
`else
    n2 = 0;
    bekle(1);
    chk("t6_yok_n2", 8'(n2), {6'd0, aktif_kaynak} - {6'd0, aktif_kaynak});
`endif

    bekle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ikaz_zamanlayici.md
# ikaz_zamanlayici

Schedules the single cabin buzzer between the two warning requests produced by the vehicle warning logic (`emniyet_kemeri_ikaz`, `kapi_ikaz`). It turns level requests into timed beep/silence patterns and arbitrates the shared buzzer, giving the door warning priority. It also limits the seat-belt warning to a fixed number of beeps. It sits between the warning logic and the buzzer driver.

## Interface
- `BIP_SURESI`, 4: buzzer-on length of one beep, in clock cycles (≥1).
- `SESSIZ_SURESI`, 4: silence after each beep, in clock cycles (≥1).
- `TEKRAR_SAYISI`, 3: number of seat-belt beeps before it self-mutes. 0 means unlimited.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: synchronous, active-high reset.
- `motor_durumu`  in  1: engine running. 0 forces idle.
- `emniyet_kemeri_ikaz`  in  1: seat-belt warning request (level).
- `kapi_ikaz`  in  1: door warning request (level).
- `sustur`  in  1: driver mute pulse. Only present with `IKAZ_SUSTURMA_EN`.
- `buzzer`  out  1: buzzer drive. Registered.
- `aktif_kaynak`  out  2: source owning the buzzer: 00 none, 01 seat belt, 10 door. Registered.
- `kemer_bitti`  out  1: seat-belt beep budget exhausted. Registered.

## Operation
- The FSM has three states: BOSTA, BIP and SESSIZ.
  - `buzzer` = 1 only in BIP.
  - `aktif_kaynak` holds the latched source in BIP and SESSIZ, and is 00 in BOSTA.
- A request is *eligible* when all of the following hold:
  - `motor_durumu` = 1.
  - The request is high.
  - It is not muted.
  - For the seat belt only, `kemer_bitti` = 0.
- **Arbitration** happens in BOSTA and at the last SESSIZ cycle only. The door has priority over the seat belt.
  - If the winner is eligible, go to BIP and latch the winner as source.
  - Otherwise go to BOSTA.
- **BIP → SESSIZ** after `BIP_SURESI` cycles.
- **At the end of SESSIZ:**
  - If the source is the seat belt, increment the beep counter.
  - When the counter reaches `TEKRAR_SAYISI` (nonzero), set `kemer_bitti`.
  - Door beeps are never counted and never self-mute.
- **No mid-beep preemption.** A door request arriving while the seat belt owns the buzzer waits until the current BIP+SESSIZ completes.
- **Active source request drops** (in BIP or SESSIZ): go to BOSTA on the next edge and reset the phase counter.
- **`emniyet_kemeri_ikaz` = 0:**
  - Clears the seat-belt beep counter and `kemer_bitti`.
  - Reasserting it restarts the full budget.
  - The counter is preserved while the door preempts, provided the seat-belt request stays high.
- **`motor_durumu` = 0:**
  - Go to BOSTA next edge.
  - Clear the phase counter, beep counter, `kemer_bitti` and mute flags.
- **`rst` = 1:**
  - State BOSTA; all counters and flags 0.
  - `buzzer` = 0, `aktif_kaynak` = 00, `kemer_bitti` = 0.
  - `rst` has priority over all other inputs.

## Timing
- Request high at edge N while in BOSTA: BIP, `buzzer` = 1 and `aktif_kaynak` valid from edge N+1.
- `buzzer` is high exactly `BIP_SURESI` cycles and low exactly `SESSIZ_SURESI` cycles. The pattern period is their sum, with no gap cycle between SESSIZ and the next BIP.
- Source drop, `motor_durumu` drop or mute sampled at edge N: `buzzer` = 0 and `aktif_kaynak` = 00 from N+1.
- `kemer_bitti` rises on the same edge that leaves the final counted SESSIZ.
- Both requests rising on the same edge in BOSTA: the door wins.

## Configuration
- `IKAZ_SUSTURMA_EN` defined: the `sustur` port exists.
  - `sustur` high while in BIP or SESSIZ sets a mute flag for the current source and forces BOSTA next edge.
  - A muted source is ineligible until its request deasserts, which clears its flag.
  - `sustur` in BOSTA is ignored.
- Not defined: no `sustur` port. Mute flags are constant 0 and all other behaviour is identical.

## Test plan
1. Reset with both requests high, then deassert → all outputs 0 during reset; BIP starts on the first edge after `rst` falls.
2. Default parameters, `motor_durumu` = 1, seat belt held high → `buzzer` runs 4 high / 4 low three times with `aktif_kaynak` = 01, then stays 0. `kemer_bitti` = 1 from cycle 24 after the first BIP.
3. Seat belt drops in cycle 2 of the second BIP → `buzzer` = 0 and `aktif_kaynak` = 00 next cycle, `kemer_bitti` = 0. Reassert → three fresh beeps.
4. Door asserted in cycle 1 of the first seat-belt BIP → the seat-belt beep and silence complete, then `aktif_kaynak` = 10 with beeps indefinitely. Dropping the door resumes the seat belt with 2 beeps remaining.
5. `motor_durumu` → 0 mid-BIP with the door active → `buzzer` = 0 next cycle; no beeps while it stays 0.
6. With `IKAZ_SUSTURMA_EN`, `sustur` pulse during a door BIP → `buzzer` = 0 next cycle and the seat belt takes over if eligible. The door stays silent until `kapi_ikaz` falls and rises.
